// File: rtl/rv_iopmp_err_capture.sv
// IOPMP error capture: latches the first faulting transaction,
// counts the errors lost while a record is held, and drives irq and bus-error.
module rv_iopmp_err_capture #(
    parameter int ADDR_WIDTH     = 64,
    parameter int RRID_WIDTH     = 16,
    parameter int LOST_CNT_WIDTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      chk_valid_i,
    input  logic                      err_transaction_i,
    input  logic [2:0]                err_type_i,
    input  logic [15:0]               err_entry_index_i,
    input  logic [ADDR_WIDTH-1:0]     txn_addr_i,
    input  logic [RRID_WIDTH-1:0]     txn_rrid_i,
    input  logic [1:0]                txn_ttype_i,
    input  logic                      ie_i,
    input  logic                      rs_i,
    input  logic                      sw_clear_i,
    output logic                      err_v_o,
    output logic [1:0]                err_ttype_o,
    output logic [2:0]                err_etype_o,
    output logic [15:0]               err_eid_o,
    output logic [ADDR_WIDTH-1:0]     err_addr_o,
    output logic [RRID_WIDTH-1:0]     err_rrid_o,
    output logic [LOST_CNT_WIDTH-1:0] lost_cnt_o,
    output logic                      irq_o,
    output logic                      bus_err_o
);

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } state_e;

    state_e state_q, state_d;

    logic                      err_event;
    logic                      capture;
    logic                      lost_inc;
    logic                      lost_clr;
    logic                      err_v_next;
    logic [1:0]                ttype_q;
    logic [2:0]                etype_q;
    logic [15:0]               eid_q;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [RRID_WIDTH-1:0]     rrid_q;
    logic [LOST_CNT_WIDTH-1:0] lost_q;
    logic                      irq_q;
    logic                      bus_err_q;

    assign err_event = chk_valid_i & err_transaction_i;

    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        lost_inc = 1'b0;
        lost_clr = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (err_event) begin
                    capture = 1'b1;
                    state_d = HELD;
                end
            end
            HELD: begin
                // A clear wins first, so a same-cycle error is captured fresh.
                if (sw_clear_i) begin
                    lost_clr = 1'b1;
                    if (err_event) begin
                        capture = 1'b1;
                    end else begin
                        state_d = EMPTY;
                    end
                end else if (err_event) begin
                    lost_inc = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    assign err_v_next = (state_d == HELD);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= EMPTY;
            ttype_q   <= '0;
            etype_q   <= '0;
            eid_q     <= '0;
            addr_q    <= '0;
            rrid_q    <= '0;
            lost_q    <= '0;
            irq_q     <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            irq_q     <= err_v_next & ie_i;
            bus_err_q <= err_event & ~rs_i;
            if (capture) begin
                ttype_q <= txn_ttype_i;
                etype_q <= err_type_i;
                eid_q   <= err_entry_index_i;
                addr_q  <= txn_addr_i;
                rrid_q  <= txn_rrid_i;
            end
            if (lost_clr) begin
                lost_q <= '0;
            end else if (lost_inc && (lost_q != '1)) begin
                lost_q <= lost_q + 1'b1;
            end
        end
    end

    assign err_v_o     = (state_q == HELD);
    assign err_ttype_o = ttype_q;
    assign err_etype_o = etype_q;
    assign err_eid_o   = eid_q;
    assign err_addr_o  = addr_q;
    assign err_rrid_o  = rrid_q;
    assign lost_cnt_o  = lost_q;
    assign irq_o       = irq_q;
    assign bus_err_o   = bus_err_q;

endmodule

// File: tb/tb_rv_iopmp_err_capture.sv
// Directed bench for rv_iopmp_err_capture.
// A second instance with a 2-bit lost counter checks saturation.
module tb_rv_iopmp_err_capture;

    logic        clk;
    logic        rst_ni;
    logic        chk_valid;
    logic        err_tr;
    logic [2:0]  err_type;
    logic [15:0] err_eid;
    logic [63:0] txn_addr;
    logic [15:0] txn_rrid;
    logic [1:0]  txn_ttype;
    logic        ie;
    logic        rs;
    logic        sw_clear;

    logic        v_o, irq_o, be_o;
    logic [1:0]  ttype_o;
    logic [2:0]  etype_o;
    logic [15:0] eid_o;
    logic [63:0] addr_o;
    logic [15:0] rrid_o;
    logic [7:0]  lost_o;

    logic        n_v_o, n_irq_o, n_be_o;
    logic [1:0]  n_ttype_o;
    logic [2:0]  n_etype_o;
    logic [15:0] n_eid_o;
    logic [63:0] n_addr_o;
    logic [15:0] n_rrid_o;
    logic [1:0]  n_lost_o;

    int n_chk;
    int n_fail;

    rv_iopmp_err_capture u_dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .chk_valid_i      (chk_valid),
        .err_transaction_i(err_tr),
        .err_type_i       (err_type),
        .err_entry_index_i(err_eid),
        .txn_addr_i       (txn_addr),
        .txn_rrid_i       (txn_rrid),
        .txn_ttype_i      (txn_ttype),
        .ie_i             (ie),
        .rs_i             (rs),
        .sw_clear_i       (sw_clear),
        .err_v_o          (v_o),
        .err_ttype_o      (ttype_o),
        .err_etype_o      (etype_o),
        .err_eid_o        (eid_o),
        .err_addr_o       (addr_o),
        .err_rrid_o       (rrid_o),
        .lost_cnt_o       (lost_o),
        .irq_o            (irq_o),
        .bus_err_o        (be_o)
    );

    rv_iopmp_err_capture #(.LOST_CNT_WIDTH(2)) u_narrow (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .chk_valid_i      (chk_valid),
        .err_transaction_i(err_tr),
        .err_type_i       (err_type),
        .err_entry_index_i(err_eid),
        .txn_addr_i       (txn_addr),
        .txn_rrid_i       (txn_rrid),
        .txn_ttype_i      (txn_ttype),
        .ie_i             (ie),
        .rs_i             (rs),
        .sw_clear_i       (sw_clear),
        .err_v_o          (n_v_o),
        .err_ttype_o      (n_ttype_o),
        .err_etype_o      (n_etype_o),
        .err_eid_o        (n_eid_o),
        .err_addr_o       (n_addr_o),
        .err_rrid_o       (n_rrid_o),
        .lost_cnt_o       (n_lost_o),
        .irq_o            (n_irq_o),
        .bus_err_o        (n_be_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        chk_valid = 1'b0;
        err_tr    = 1'b0;
        sw_clear  = 1'b0;
    endtask

    task automatic drv_err(input logic [2:0] t, input logic [15:0] e,
                           input logic [63:0] a, input logic [15:0] r,
                           input logic [1:0] tt);
        chk_valid = 1'b1;
        err_tr    = 1'b1;
        err_type  = t;
        err_eid   = e;
        txn_addr  = a;
        txn_rrid  = r;
        txn_ttype = tt;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_ni = 1'b0;
        idle();
        err_type  = '0;
        err_eid   = '0;
        txn_addr  = '0;
        txn_rrid  = '0;
        txn_ttype = '0;
        ie = 1'b1;
        rs = 1'b0;
        #1;
        check("rst_v", v_o, 0);
        check("rst_irq", irq_o, 0);
        check("rst_be", be_o, 0);
        check("rst_lost", lost_o, 0);
        check("rst_addr", addr_o, 0);
        check("rst_eid", eid_o, 0);
        repeat (2) tick();
        rst_ni = 1'b1;
        tick();

        // First error is captured.
        drv_err(3'd2, 16'd5, 64'h8000_1000, 16'd3, 2'd2);
        tick();
        idle();
        check("cap_v", v_o, 1);
        check("cap_etype", etype_o, 2);
        check("cap_eid", eid_o, 5);
        check("cap_addr", addr_o, 64'h8000_1000);
        check("cap_rrid", rrid_o, 3);
        check("cap_ttype", ttype_o, 2);
        check("cap_irq", irq_o, 1);
        check("cap_be", be_o, 1);
        check("cap_lost", lost_o, 0);
        tick();
        check("cap_be_end", be_o, 0);
        check("cap_irq_hold", irq_o, 1);

        // Three lost errors, back to back.
        for (int i = 0; i < 3; i++) begin
            drv_err(3'd1, 16'(6 + i), 64'h9000_0000 + 64'(i), 16'(7 + i), 2'd1);
            tick();
            check("lost_be", be_o, 1);
        end
        idle();
        check("lost_eid", eid_o, 5);
        check("lost_addr", addr_o, 64'h8000_1000);
        check("lost_etype", etype_o, 2);
        check("lost_cnt3", lost_o, 3);
        check("nar_cnt3", n_lost_o, 3);
        tick();
        check("lost_be_end", be_o, 0);

        // Non-error verdict changes nothing.
        chk_valid = 1'b1;
        err_tr    = 1'b0;
        tick();
        idle();
        check("ok_be", be_o, 0);
        check("ok_lost", lost_o, 3);

        // Two more lost: wide counts on, narrow saturates.
        drv_err(3'd3, 16'd20, 64'h1234, 16'd1, 2'd0);
        repeat (2) tick();
        idle();
        check("lost_cnt5", lost_o, 5);
        check("nar_sat", n_lost_o, 3);
        check("nar_eid", n_eid_o, 5);

        // Plain clear.
        sw_clear = 1'b1;
        tick();
        idle();
        check("clr_v", v_o, 0);
        check("clr_irq", irq_o, 0);
        check("clr_lost", lost_o, 0);
        check("clr_nlost", n_lost_o, 0);
        check("clr_stale", eid_o, 5);

        // Clear while empty.
        sw_clear = 1'b1;
        tick();
        idle();
        check("clr_empty_v", v_o, 0);

        // Capture, lose one, then clear together with a new error.
        drv_err(3'd5, 16'd4, 64'h40, 16'd2, 2'd1);
        tick();
        drv_err(3'd1, 16'd8, 64'h80, 16'd2, 2'd1);
        tick();
        check("pre_lost", lost_o, 1);
        drv_err(3'd7, 16'd9, 64'hdead_beef, 16'd12, 2'd3);
        sw_clear = 1'b1;
        tick();
        idle();
        check("cc_v", v_o, 1);
        check("cc_eid", eid_o, 9);
        check("cc_etype", etype_o, 7);
        check("cc_addr", addr_o, 64'hdead_beef);
        check("cc_lost", lost_o, 0);
        check("cc_irq", irq_o, 1);
        check("cc_be", be_o, 1);

        // ie drops: irq falls next cycle.
        ie = 1'b0;
        tick();
        check("ie_off_irq", irq_o, 0);
        check("ie_off_v", v_o, 1);

        // Clear, then error with rs=1, ie=0.
        sw_clear = 1'b1;
        tick();
        idle();
        rs = 1'b1;
        drv_err(3'd2, 16'd11, 64'h5555_0000, 16'd4, 2'd2);
        tick();
        idle();
        check("rs_v", v_o, 1);
        check("rs_eid", eid_o, 11);
        check("rs_be", be_o, 0);
        check("rs_irq", irq_o, 0);

        // Asynchronous reset while held.
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_v", v_o, 0);
        check("arst_eid", eid_o, 0);
        check("arst_addr", addr_o, 0);
        check("arst_rrid", rrid_o, 0);
        check("arst_etype", etype_o, 0);
        check("arst_ttype", ttype_o, 0);
        check("arst_irq", irq_o, 0);
        check("arst_be", be_o, 0);
        check("arst_nv", n_v_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
